// File: rtl/ifde_inst_queue.sv
// ifde_inst_queue: circular instruction FIFO between fetch and decode.
// Optional same-cycle empty-path bypass under `IFDE_IQ_BYPASS_EN.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   f_valid/f_inst/f_pc/f_inter, f_ready   fetch side (f_ready -> F_en)
//   halt                     block new entries, keep draining
//   flush                    branch redirect, drop every entry
//   d_valid/d_inst/d_pc/d_inter, d_ready   decode side
//   count                    occupancy 0..DEPTH
module ifde_inst_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_valid,
    input  logic [N-1:0]  f_inst,
    input  logic [N-1:0]  f_pc,
    input  logic [1:0]    f_inter,
    output logic          f_ready,
    input  logic          halt,
    input  logic          flush,
    output logic          d_valid,
    output logic [N-1:0]  d_inst,
    output logic [N-1:0]  d_pc,
    output logic [1:0]    d_inter,
    input  logic          d_ready,
    output logic [AW:0]   count
);

    localparam int EW = 2*N + 2;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wp;
    logic [AW:0]   r_rp;

    logic          w_empty;
    logic          w_full;
    logic          w_enq;
    logic          w_deq;
    logic          w_byp;
    logic          w_wr;
    logic          w_rd;
    logic [EW-1:0] w_head;
    logic [EW-1:0] w_out;

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) &&
                     (r_wp[AW] != r_rp[AW]);

    // f_ready depends on registered state only, never on d_ready.
    assign f_ready = !w_full && !halt && !flush;
    assign w_enq   = f_valid && f_ready;
    assign w_head  = r_mem[r_rp[AW-1:0]];

`ifdef IFDE_IQ_BYPASS_EN
    assign w_byp = w_empty && f_valid && !halt && !flush;
`else
    assign w_byp = 1'b0;
`endif

    assign d_valid = !w_empty || w_byp;
    assign w_deq   = d_valid && d_ready && !flush;

    // A bypassed entry consumed this cycle never touches storage.
    assign w_wr = w_enq && !(w_byp && d_ready);
    assign w_rd = w_deq && !w_byp;

    always_comb begin
        w_out = '0;
        if (w_byp)
            w_out = {f_inst, f_pc, f_inter};
        else if (!w_empty)
            w_out = w_head;
    end

    assign d_inst  = w_out[EW-1 -: N];
    assign d_pc    = w_out[N+1 -: N];
    assign d_inter = w_out[1:0];
    assign count   = r_wp - r_rp;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + (AW+1)'(1);
            if (w_rd)
                r_rp <= r_rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr)
            r_mem[r_wp[AW-1:0]] <= {f_inst, f_pc, f_inter};
    end

endmodule

// File: tb/tb_ifde_inst_queue.sv
// tb_ifde_inst_queue: scoreboard bench for ifde_inst_queue.
// Build with +define+IFDE_IQ_BYPASS_EN to check the bypass build.
module tb_ifde_inst_queue;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct packed {
        logic [N-1:0] inst;
        logic [N-1:0] pc;
        logic [1:0]   inter;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, f_valid, halt, flush, d_ready;
    logic [N-1:0]  f_inst, f_pc;
    logic [1:0]    f_inter;
    logic          f_ready, d_valid;
    logic [N-1:0]  d_inst, d_pc;
    logic [1:0]    d_inter;
    logic [AW:0]   count;

    ent_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    always #5 clk = ~clk;

    ifde_inst_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_inst(f_inst), .f_pc(f_pc),
        .f_inter(f_inter), .f_ready(f_ready),
        .halt(halt), .flush(flush),
        .d_valid(d_valid), .d_inst(d_inst), .d_pc(d_pc),
        .d_inter(d_inter), .d_ready(d_ready), .count(count)
    );

    function automatic bit exp_byp();
`ifdef IFDE_IQ_BYPASS_EN
        return sb.size() == 0 && f_valid && !halt && !flush;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_fready();
        return sb.size() < DEPTH && !halt && !flush;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Monitor: compare what the DUT presents against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            bit   v;
            ent_t h;
            v = exp_byp() || sb.size() != 0;
            h = '0;
            if (exp_byp())
                h = '{f_inst, f_pc, f_inter};
            else if (sb.size() != 0)
                h = sb[0];
            chk("count", 64'(count), 64'(sb.size()));
            chk("f_ready", 64'(f_ready), 64'(exp_fready()));
            chk("d_valid", 64'(d_valid), 64'(v));
            chk("d_pc", 64'(d_pc), 64'(h.pc));
            chk("d_inst", 64'(d_inst), 64'(h.inst));
            chk("d_inter", 64'(d_inter), 64'(h.inter));
        end
    end

    // Scoreboard update at each edge from the bench's own inputs.
    always @(posedge clk) begin
        bit byp, v, enq, deq;
        byp = exp_byp();
        v   = byp || sb.size() != 0;
        enq = f_valid && exp_fready();
        deq = v && d_ready && !flush;
        if (rst || flush) begin
            sb.delete();
        end else if (!(byp && d_ready)) begin
            if (deq)
                void'(sb.pop_front());
            if (enq)
                sb.push_back('{f_inst, f_pc, f_inter});
        end
    end

    task automatic cyc(input logic fv, input logic [N-1:0] pc,
                       input logic dr, input logic h,
                       input logic fl, input logic r);
        f_valid = fv;
        f_pc    = pc;
        f_inst  = 32'h1300_0000 | pc;
        f_inter = pc[3:2];
        d_ready = dr;
        halt    = h;
        flush   = fl;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; f_valid = 1'b0; halt = 1'b0; flush = 1'b0;
        d_ready = 1'b0; f_inst = '0; f_pc = '0; f_inter = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);

        // fill to full, try one more, then drain
        for (int i = 0; i < 4; i++)
            cyc(1, 32'(4*i), 0, 0, 0, 0);
        cyc(1, 32'h10, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        // one pre-filled entry, then streaming across the wrap
        cyc(1, 32'h00, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++)
            cyc(1, 32'(4*i), 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        // three entries, flush with enq+deq in the same cycle
        for (int i = 0; i < 3; i++)
            cyc(1, 32'(32'h100 + 4*i), 0, 0, 0, 0);
        cyc(1, 32'h1F0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);

        // halt while draining two entries
        cyc(1, 32'h200, 0, 0, 0, 0);
        cyc(1, 32'h204, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc(1, 32'(32'h300 + 4*i), 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        // full with deq: f_ready recovers only next cycle
        for (int i = 0; i < 4; i++)
            cyc(1, 32'(32'h400 + 4*i), 0, 0, 0, 0);
        cyc(1, 32'h4F0, 1, 0, 0, 0);
        cyc(1, 32'h4F4, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 1, 0, 0, 0);

        // empty path: same-cycle with bypass, next cycle without
        f_valid = 1'b1; f_pc = 32'h40; f_inst = 32'hA7C0_0000;
        f_inter = 2'b10; d_ready = 1'b1; halt = 1'b0;
        flush = 1'b0; rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        // reset mid-operation, with flush also high
        cyc(1, 32'h500, 0, 0, 0, 0);
        cyc(1, 32'h504, 0, 0, 0, 0);
        cyc(1, 32'h508, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 32'h600, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        mon_en = 1'b0;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0",
                     sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
